// File: rtl/ringer_cadence_if.sv
// Control/status bundle between the alarm controller and the cadence ringer.
// The master drives requests and config; the slave returns buzzer and status.
interface ringer_cadence_if #(
    parameter int TONE_W  = 16,
    parameter int MS_W    = 12,
    parameter int BURST_W = 8
);
    logic              start;
    logic              stop;
    logic [TONE_W-1:0] half_period_a;
    logic [TONE_W-1:0] half_period_b;
    logic [MS_W-1:0]   on_ms;
    logic [MS_W-1:0]   off_ms;
    logic [BURST_W-1:0] bursts;
    logic              sound;
    logic              busy;
    logic              burst_active;
    logic              done;

    modport master (
        output start, stop, half_period_a, half_period_b,
        output on_ms, off_ms, bursts,
        input  sound, busy, burst_active, done
    );

    modport slave (
        input  start, stop, half_period_a, half_period_b,
        input  on_ms, off_ms, bursts,
        output sound, busy, burst_active, done
    );
endinterface

// File: rtl/ringer_cadence.sv
// Cadence ringer: square-wave tone gated into on/off bursts, counted or continuous.
// Optional two-tone warble within each burst is enabled by RINGER_WARBLE_EN.
module ringer_cadence #(
    parameter int CLK_FREQ  = 50000000,
    parameter int TONE_W    = 16,
    parameter int MS_W      = 12,
    parameter int BURST_W   = 8,
    parameter int WARBLE_MS = 50
) (
    input logic             clk,
    input logic             rst_n,
    ringer_cadence_if.slave bus
);
    localparam int TICKS = CLK_FREQ / 1000;
    localparam int PRE_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS - 1);

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_e;

    state_e             state_q;
    logic [TONE_W-1:0]  hpa_q;
    logic [TONE_W-1:0]  tone_q;
    logic [MS_W-1:0]    on_q;
    logic [MS_W-1:0]    off_q;
    logic [MS_W-1:0]    ms_q;
    logic [BURST_W-1:0] bursts_q;
    logic [BURST_W-1:0] bcnt_q;
    logic [PRE_W-1:0]   pre_q;
    logic               sound_q;
    logic               busy_q;
    logic               act_q;
    logic               done_q;

    logic [TONE_W-1:0]  hp;
    logic [BURST_W-1:0] bcnt_d;
    logic               accept;
    logic               ms_tick;
    logic               tone_end;
    logic               gap_end;
    logic               last_burst;
    logic               tone_wrap;
    logic               audible;
    logic               slot_sw;

    assign accept     = (state_q == IDLE) && bus.start && !bus.stop;
    assign ms_tick    = (pre_q == PRE_MAX);
    assign tone_end   = (state_q == TONE) && ms_tick && (ms_q == on_q - MS_W'(1));
    assign gap_end    = (state_q == GAP) && ms_tick && (ms_q == off_q - MS_W'(1));
    assign last_burst = (bursts_q != '0) && (bcnt_q == bursts_q);
    assign bcnt_d     = (&bcnt_q) ? bcnt_q : bcnt_q + BURST_W'(1);
    assign audible    = (hp > TONE_W'(1));
    assign tone_wrap  = (tone_q == hp - TONE_W'(1));

`ifdef RINGER_WARBLE_EN
    localparam int WT     = WARBLE_MS * TICKS;
    localparam int SLOT_W = (WT > 1) ? $clog2(WT) : 1;

    logic [TONE_W-1:0] hpb_q;
    logic [SLOT_W-1:0] slot_q;
    logic              sel_q;

    assign hp      = sel_q ? hpb_q : hpa_q;
    assign slot_sw = (state_q == TONE) && !tone_end
                   && (slot_q == SLOT_W'(WT - 1));

    // Slot timer restarts on every tone entry, so each burst begins on tone a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpb_q  <= '0;
            slot_q <= '0;
            sel_q  <= 1'b0;
        end else begin
            if (accept) hpb_q <= bus.half_period_b;
            if (state_q != TONE || tone_end) begin
                slot_q <= '0;
                sel_q  <= 1'b0;
            end else if (slot_sw) begin
                slot_q <= '0;
                sel_q  <= ~sel_q;
            end else begin
                slot_q <= slot_q + SLOT_W'(1);
            end
        end
    end
`else
    assign hp      = hpa_q;
    assign slot_sw = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hpa_q    <= '0;
            tone_q   <= '0;
            on_q     <= '0;
            off_q    <= '0;
            ms_q     <= '0;
            bursts_q <= '0;
            bcnt_q   <= '0;
            pre_q    <= '0;
            sound_q  <= 1'b0;
            busy_q   <= 1'b0;
            act_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        hpa_q    <= bus.half_period_a;
                        on_q     <= bus.on_ms;
                        off_q    <= bus.off_ms;
                        bursts_q <= bus.bursts;
                        if (bus.on_ms == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= TONE;
                            bcnt_q  <= BURST_W'(1);
                            busy_q  <= 1'b1;
                            act_q   <= 1'b1;
                            tone_q  <= '0;
                            sound_q <= 1'b0;
                            pre_q   <= '0;
                            ms_q    <= '0;
                        end
                    end
                end
                default: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        act_q   <= 1'b0;
                        sound_q <= 1'b0;
                        tone_q  <= '0;
                        pre_q   <= '0;
                        ms_q    <= '0;
                        bcnt_q  <= '0;
                    end else begin
                        pre_q <= ms_tick ? '0 : pre_q + PRE_W'(1);
                        ms_q  <= ms_tick ? ms_q + MS_W'(1) : ms_q;
                        if (state_q == TONE) begin
                            if (slot_sw) begin
                                tone_q <= '0;
                            end else if (tone_wrap) begin
                                tone_q  <= '0;
                                sound_q <= audible & ~sound_q;
                            end else begin
                                tone_q <= tone_q + TONE_W'(1);
                            end
                            if (!audible) sound_q <= 1'b0;
                        end
                        // Back-to-back bursts keep the tone phase running.
                        if (tone_end) begin
                            pre_q <= '0;
                            ms_q  <= '0;
                            if (last_burst) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                act_q   <= 1'b0;
                                sound_q <= 1'b0;
                                tone_q  <= '0;
                                bcnt_q  <= '0;
                            end else if (off_q == '0) begin
                                bcnt_q <= bcnt_d;
                            end else begin
                                state_q <= GAP;
                                act_q   <= 1'b0;
                                sound_q <= 1'b0;
                                tone_q  <= '0;
                            end
                        end
                        if (gap_end) begin
                            state_q <= TONE;
                            bcnt_q  <= bcnt_d;
                            act_q   <= 1'b1;
                            sound_q <= 1'b0;
                            tone_q  <= '0;
                            pre_q   <= '0;
                            ms_q    <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.sound        = sound_q;
    assign bus.busy         = busy_q;
    assign bus.burst_active = act_q;
    assign bus.done         = done_q;
endmodule
